// File: rtl/spsram_rd_ctrl_if.sv
// Request and response handshake bundle for spsram_rd_ctrl.
// The master side issues requests and consumes responses.
interface spsram_rd_ctrl_if #(
    parameter int W         = 32,
    parameter int AW        = 7,
    parameter int MOMENTO_W = 4
);
    logic                 req_vld;
    logic                 req_wen;
    logic [AW-1:0]        req_addr;
    logic [W-1:0]         req_din;
    logic [MOMENTO_W-1:0] req_momento;
    logic                 req_rdy;

    logic                 rsp_vld;
    logic [W-1:0]         rsp_dout;
    logic [MOMENTO_W-1:0] rsp_momento;
    logic                 rsp_rdy;

    modport master (
        output req_vld, req_wen, req_addr, req_din, req_momento,
        input  req_rdy,
        input  rsp_vld, rsp_dout, rsp_momento,
        output rsp_rdy
    );

    modport slave (
        input  req_vld, req_wen, req_addr, req_din, req_momento,
        output req_rdy,
        output rsp_vld, rsp_dout, rsp_momento,
        input  rsp_rdy
    );
endinterface

// File: rtl/spsram_rd_ctrl.sv
// Read/write front end for a pipelined single-port SRAM.
// Credit-gated reads land in an in-order response FIFO.
module spsram_rd_ctrl #(
    parameter int W         = 32,
    parameter int N         = 128,
    parameter int LATENCY_N = 1,
    parameter int MOMENTO_W = 4,
    parameter int DEPTH     = 4,
    localparam int AW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    spsram_rd_ctrl_if.slave      bus,
    output logic                 mem_en,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_addr,
    output logic [W-1:0]         mem_din,
    output logic [MOMENTO_W-1:0] mem_momento,
    input  logic [W-1:0]         mem_dout_r,
    input  logic [MOMENTO_W-1:0] mem_momento_r,
    output logic                 idle
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = W + MOMENTO_W;

    logic [OW-1:0]        occ;
    logic [OW-1:0]        cnt;
    logic [PW-1:0]        wp;
    logic [PW-1:0]        rp;
    logic [LATENCY_N-1:0] vld_pipe;
    logic [EW-1:0]        fifo [DEPTH];

    logic accept;
    logic rd_acc;
    logic push;
    logic pop;
    logic empty;
    logic full;

    // occ covers reads in the SRAM pipe as well as buffered ones,
    // so a free credit always means a free FIFO slot on arrival.
    assign bus.req_rdy = rst & (bus.req_wen | (occ != OW'(DEPTH)));
    assign accept      = bus.req_vld & bus.req_rdy;
    assign rd_acc      = accept & ~bus.req_wen;

    assign mem_en      = accept;
    assign mem_wen     = bus.req_wen;
    assign mem_addr    = bus.req_addr;
    assign mem_din     = bus.req_din;
    assign mem_momento = bus.req_momento;

    assign empty = (cnt == '0);
    assign full  = (cnt == OW'(DEPTH));
    assign push  = vld_pipe[LATENCY_N-1];
    assign pop   = bus.rsp_vld & bus.rsp_rdy;

    assign bus.rsp_vld = ~empty;
    assign {bus.rsp_dout, bus.rsp_momento} = empty ? '0 : fifo[rp];
    assign idle = (occ == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ      <= '0;
            cnt      <= '0;
            wp       <= '0;
            rp       <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= LATENCY_N'({vld_pipe, rd_acc});
            case ({rd_acc, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push) begin
                wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            end
            if (pop) begin
                rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wp] <= {mem_dout_r, mem_momento_r};
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst) !(push && full));
    a_occ_bound: assert property (
        @(posedge clk) disable iff (!rst) occ <= OW'(DEPTH));
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst) !(pop && empty));
endmodule

// File: tb/tb_spsram_rd_ctrl.sv
// Randomized bench for spsram_rd_ctrl with a queue-based response model.
// Includes a behavioural pipelined SRAM feeding the read-return path.
module tb_spsram_rd_ctrl;
    localparam int W   = 32;
    localparam int N   = 128;
    localparam int AW  = 7;
    localparam int MW  = 4;
    localparam int L   = 2;
    localparam int D   = 4;

    typedef struct {
        logic [W-1:0]  d;
        logic [MW-1:0] m;
        int            avail;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din;
    logic [MW-1:0] mem_momento;
    logic [W-1:0]  mem_dout_r;
    logic [MW-1:0] mem_momento_r;
    logic          idle;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    exp_t         q[$];
    logic [W-1:0] ref_mem [N];

    logic [W-1:0]  sram  [N];
    logic [W-1:0]  dpipe [L];
    logic [MW-1:0] mpipe [L];

    spsram_rd_ctrl_if #(.W(W), .AW(AW), .MOMENTO_W(MW)) bus ();

    spsram_rd_ctrl #(
        .W(W), .N(N), .LATENCY_N(L), .MOMENTO_W(MW), .DEPTH(D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_momento   (mem_momento),
        .mem_dout_r    (mem_dout_r),
        .mem_momento_r (mem_momento_r),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM with L-cycle read latency; idle slots return noise
    always @(posedge clk) begin
        if (mem_en && mem_wen) sram[mem_addr] <= mem_din;
        if (mem_en && !mem_wen) begin
            dpipe[0] <= sram[mem_addr];
            mpipe[0] <= mem_momento;
        end else begin
            dpipe[0] <= $urandom;
            mpipe[0] <= MW'($urandom);
        end
        for (int i = 1; i < L; i++) begin
            dpipe[i] <= dpipe[i-1];
            mpipe[i] <= mpipe[i-1];
        end
    end

    assign mem_dout_r    = dpipe[L-1];
    assign mem_momento_r = mpipe[L-1];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic w,
                        input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [MW-1:0] m, input logic rr);
        logic exp_rdy;
        logic exp_vld;
        logic acc;
        bus.req_vld     = v;
        bus.req_wen     = w;
        bus.req_addr    = a;
        bus.req_din     = d;
        bus.req_momento = m;
        bus.rsp_rdy     = rr;
        @(negedge clk);
        exp_rdy = w | (q.size() < D);
        exp_vld = (q.size() != 0) && (q[0].avail <= cyc);
        chk("req_rdy", bus.req_rdy, exp_rdy);
        chk("rsp_vld", bus.rsp_vld, exp_vld);
        chk("idle", idle, q.size() == 0);
        if (exp_vld) begin
            chk("rsp_dout", bus.rsp_dout, q[0].d);
            chk("rsp_momento", bus.rsp_momento, q[0].m);
        end
        acc = v & exp_rdy;
        chk("mem_en", mem_en, acc);
        if (acc) begin
            chk("mem_wen", mem_wen, w);
            chk("mem_addr", mem_addr, a);
            if (w) begin
                chk("mem_din", mem_din, d);
                ref_mem[a] = d;
            end else begin
                chk("mem_momento", mem_momento, m);
                q.push_back('{d: ref_mem[a], m: m, avail: cyc + L + 1});
            end
        end
        if (exp_vld && rr) void'(q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_vld = 1'b0;
        bus.req_wen = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_rsp_vld", bus.rsp_vld, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_req_rdy", bus.req_rdy, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    initial begin
        bus.req_vld     = 1'b0;
        bus.req_wen     = 1'b1;
        bus.req_addr    = '0;
        bus.req_din     = '0;
        bus.req_momento = '0;
        bus.rsp_rdy     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_vld", bus.rsp_vld, 1'b0);
        chk("reset_rsp_dout", bus.rsp_dout, '0);
        chk("reset_rsp_momento", bus.rsp_momento, '0);
        chk("reset_idle", idle, 1'b1);
        chk("reset_req_rdy", bus.req_rdy, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < N; i++) step(1'b1, 1'b1, AW'(i), $urandom, '0, 1'b0);

        step(1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 4'd3, 1'b1);
        step(1'b1, 1'b0, 7'd5, '0, 4'd7, 1'b1);
        drain(4);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), '0, MW'(i), 1'b1);
        drain(5);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, AW'(i + 10), '0, MW'(i), 1'b0);
        step(1'b1, 1'b1, 7'd40, 32'h1234_5678, '0, 1'b0);
        step(1'b1, 1'b0, 7'd15, '0, 4'd5, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        step(1'b1, 1'b0, 7'd14, '0, 4'd4, 1'b1);
        step(1'b1, 1'b0, 7'd15, '0, 4'd5, 1'b1);
        drain(5);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(i + 20), '0, MW'(i), 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 7'd30, '0, 4'd9, 1'b1);
        step(1'b1, 1'b0, 7'd30, '0, 4'd9, 1'b0);
        drain(8);

        step(1'b1, 1'b0, 7'd50, '0, 4'd1, 1'b1);
        step(1'b1, 1'b0, 7'd51, '0, 4'd2, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        step(1'b1, 1'b0, 7'd52, '0, 4'd3, 1'b1);
        drain(4);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 3,
                     AW'($urandom_range(0, N - 1)),
                     $urandom,
                     MW'($urandom),
                     $urandom_range(0, 9) < 6);
            end
        end
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
